// File: rtl/dand_meas_pkg.sv
// rtl/dand_meas_pkg.sv - shared types and decode helpers for the dand measurement controller
package dand_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SAMPLE,
    ST_RELAX0,
    ST_RELAX1,
    ST_DONE
  } meas_state_t;

  // Number of low cycles between launches so the delay line fully discharges.
  localparam int RELAX_LEN = 2;

  // Helpers operate on a fixed wide vector; callers zero-extend their TAPS-wide code.
  localparam int TAPS_MAX = 32;
  localparam int PC_W     = $clog2(TAPS_MAX + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [TAPS_MAX-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < TAPS_MAX; i++) begin
      cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

  // A thermometer code is ones contiguous from bit 0; adding one then clears every set bit.
  // Zero-extension keeps the all-ones TAPS-wide code valid.
  function automatic logic is_thermo(input logic [TAPS_MAX-1:0] v);
    return (v & (v + TAPS_MAX'(1))) == '0;
  endfunction

endpackage

// File: rtl/thermo_decode.sv
// rtl/thermo_decode.sv - combinational tap-vector to count/bubble decoder
module thermo_decode
  import dand_meas_pkg::*;
#(
  parameter int TAPS = 7,
  parameter int CW   = $clog2(TAPS + 1)
) (
  input  logic [TAPS-1:0] tap_i,
  output logic [CW-1:0]   count_o,
  output logic            bubble_o
);

  logic [TAPS_MAX-1:0] tap_ext;

  assign tap_ext  = TAPS_MAX'(tap_i);
  assign count_o  = CW'(popcount(tap_ext));
  assign bubble_o = !is_thermo(tap_ext);

endmodule

// File: rtl/dand_meas_ctrl.sv
// rtl/dand_meas_ctrl.sv - launches dand trials, decodes captured taps, accumulates sum/min/max/bubble
module dand_meas_ctrl
  import dand_meas_pkg::*;
#(
  parameter int TAPS        = 7,
  parameter int TRIALS_LOG2 = 2,
  localparam int CW         = $clog2(TAPS + 1),
  localparam int SW         = CW + TRIALS_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [TAPS-1:0] tap_i,
  output logic            launch_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CW-1:0]   count_o,
  output logic [SW-1:0]   sum_o,
  output logic [CW-1:0]   min_o,
  output logic [CW-1:0]   max_o,
  output logic            bubble_o
);

  meas_state_t            state, next_state;
  logic [TRIALS_LOG2-1:0] trial;
  logic [SW-1:0]          sum_acc, sum_next;
  logic [CW-1:0]          min_acc, max_acc, min_next, max_next;
  logic                   bub_acc, bub_next;
  logic [CW-1:0]          dec_count;
  logic                   dec_bubble;
  logic                   last_trial;
  logic                   run_start;

  thermo_decode #(.TAPS(TAPS), .CW(CW)) u_decode (
    .tap_i    (tap_i),
    .count_o  (dec_count),
    .bubble_o (dec_bubble)
  );

  assign last_trial = (trial == '1);
  assign run_start  = (state == ST_IDLE) && start_i;

  // Accumulator values as they would stand after folding in the current sample.
  always_comb begin
    sum_next = sum_acc + SW'(dec_count);
    min_next = (dec_count < min_acc) ? dec_count : min_acc;
    max_next = (dec_count > max_acc) ? dec_count : max_acc;
    bub_next = bub_acc | dec_bubble;
  end

  // Next-state logic; start is only looked at in IDLE so requests elsewhere are dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_i) next_state = ST_LAUNCH;
      ST_LAUNCH: next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = last_trial ? ST_DONE : ST_RELAX0;
      ST_RELAX0: next_state = (RELAX_LEN > 1) ? ST_RELAX1 : ST_LAUNCH;
      ST_RELAX1: next_state = ST_LAUNCH;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Control outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      launch_o <= (next_state == ST_LAUNCH);
      busy_o   <= (next_state == ST_LAUNCH) || (next_state == ST_SAMPLE) ||
                  (next_state == ST_RELAX0) || (next_state == ST_RELAX1);
      done_o   <= (next_state == ST_DONE);
    end
  end

  // Trial counter, accumulators and result registers; results change only entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trial    <= '0;
      sum_acc  <= '0;
      min_acc  <= '0;
      max_acc  <= '0;
      bub_acc  <= 1'b0;
      count_o  <= '0;
      sum_o    <= '0;
      min_o    <= '0;
      max_o    <= '0;
      bubble_o <= 1'b0;
    end else if (run_start) begin
      trial    <= '0;
      sum_acc  <= '0;
      min_acc  <= '1;
      max_acc  <= '0;
      bub_acc  <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      trial    <= trial + 1'b1;
      sum_acc  <= sum_next;
      min_acc  <= min_next;
      max_acc  <= max_next;
      bub_acc  <= bub_next;
      count_o  <= dec_count;
      if (last_trial) begin
        sum_o    <= sum_next;
        min_o    <= min_next;
        max_o    <= max_next;
        bubble_o <= bub_next;
      end
    end
  end

endmodule

// File: tb/tb_dand_meas_ctrl.sv
// tb/tb_dand_meas_ctrl.sv - directed self-checking bench for dand_meas_ctrl
module tb_dand_meas_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [6:0] tap_i;
  logic       launch_o, busy_o, done_o, bubble_o;
  logic [2:0] count_o, min_o, max_o;
  logic [4:0] sum_o;

  int n_checks;
  int n_errors;

  dand_meas_ctrl #(.TAPS(7), .TRIALS_LOG2(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .tap_i    (tap_i),
    .launch_o (launch_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .count_o  (count_o),
    .sum_o    (sum_o),
    .min_o    (min_o),
    .max_o    (max_o),
    .bubble_o (bubble_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is in an IDLE cycle; that cycle becomes cycle 0 of the run.
  // taps/ecnt are packed {trial3, trial2, trial1, trial0}.
  task automatic do_run(input string nm, input logic [3:0][6:0] taps,
                        input logic [3:0][3:0] ecnt, input int hold,
                        input int es, input int emn, input int emx, input int eb,
                        input int ps, input int pmn, input int pmx, input int pb);
    start_i = 1'b1;
    check_eq({nm, "_c0_launch"}, launch_o, 0);
    check_eq({nm, "_c0_done"}, done_o, 0);
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == hold) start_i = 1'b0;
      if ((c - 1) % 4 == 0) tap_i = taps[(c - 1) / 4];
      check_eq($sformatf("%s_c%0d_launch", nm, c), launch_o, ((c - 1) % 4 == 0) ? 1 : 0);
      check_eq($sformatf("%s_c%0d_busy", nm, c), busy_o, (c <= 14) ? 1 : 0);
      check_eq($sformatf("%s_c%0d_done", nm, c), done_o, (c == 15) ? 1 : 0);
      if (c >= 3 && (c - 3) % 4 == 0)
        check_eq($sformatf("%s_c%0d_count", nm, c), count_o, int'(ecnt[(c - 3) / 4]));
      if (c < 15) begin
        check_eq($sformatf("%s_c%0d_hold_sum", nm, c), sum_o, ps);
        check_eq($sformatf("%s_c%0d_hold_min", nm, c), min_o, pmn);
        check_eq($sformatf("%s_c%0d_hold_max", nm, c), max_o, pmx);
        check_eq($sformatf("%s_c%0d_hold_bub", nm, c), bubble_o, pb);
      end
    end
    check_eq({nm, "_sum"}, sum_o, es);
    check_eq({nm, "_min"}, min_o, emn);
    check_eq({nm, "_max"}, max_o, emx);
    check_eq({nm, "_bubble"}, bubble_o, eb);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    tap_i    = '0;
    step();
    step();
    check_eq("rst_launch", launch_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_bubble", bubble_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_sum", sum_o, 0);
    check_eq("rst_min", min_o, 0);
    check_eq("rst_max", max_o, 0);
    rst_n = 1'b1;
    step();

    do_run("const3", {7'b0000111, 7'b0000111, 7'b0000111, 7'b0000111},
           {4'd3, 4'd3, 4'd3, 4'd3}, 1, 12, 3, 3, 0, 0, 0, 0, 0);
    step();
    do_run("mixed", {7'b0011111, 7'b0000000, 7'b1111111, 7'b0000001},
           {4'd5, 4'd0, 4'd7, 4'd1}, 1, 13, 0, 7, 0, 12, 3, 3, 0);
    step();
    do_run("bubble", {7'b0000011, 7'b0000011, 7'b0000101, 7'b0000011},
           {4'd2, 4'd2, 4'd2, 4'd2}, 1, 8, 2, 2, 1, 13, 0, 7, 0);
    step();
    // start held for cycles 0..19: one run, then a second run accepted in cycle 16
    do_run("held1", {7'b0000111, 7'b0000111, 7'b0000111, 7'b0000111},
           {4'd3, 4'd3, 4'd3, 4'd3}, 99, 12, 3, 3, 0, 8, 2, 2, 1);
    step();
    do_run("held2", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111},
           {4'd7, 4'd7, 4'd7, 4'd7}, 4, 28, 7, 7, 0, 12, 3, 3, 0);
    start_i = 1'b0;

    // reset in cycle 6 of a run
    step();
    start_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        start_i = 1'b0;
        tap_i   = 7'b0001111;
      end
    end
    check_eq("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_launch", launch_o, 0);
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_done", done_o, 0);
    check_eq("mid_rst_bubble", bubble_o, 0);
    check_eq("mid_rst_count", count_o, 0);
    check_eq("mid_rst_sum", sum_o, 0);
    check_eq("mid_rst_min", min_o, 0);
    check_eq("mid_rst_max", max_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("in_rst_done_%0d", i), done_o, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq($sformatf("post_rst_done_%0d", i), done_o, 0);
      check_eq($sformatf("post_rst_busy_%0d", i), busy_o, 0);
    end
    do_run("fresh", {7'b0111111, 7'b0000011, 7'b0001111, 7'b0000001},
           {4'd6, 4'd2, 4'd4, 4'd1}, 1, 13, 1, 6, 0, 0, 0, 0, 0);
    step();
    check_eq("idle_done", done_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
